// File: rtl/instr_fetch_queue.sv
// Instruction fetch queue: a loadable program memory, a PC, and a circular
// queue of {instr, pc} entries for the consumer. Fetching HALT_WORD stops
// fetch, and a redirect flushes the queue and reloads the PC.
module instr_fetch_queue #(
  parameter int                 INSTR_W   = 16,
  parameter int                 ADDR_W    = 4,
  parameter int                 QDEPTH    = 4,
  parameter logic [INSTR_W-1:0] HALT_WORD = INSTR_W'(16'hFFFF)
) (
  input  logic                          clk1,
  input  logic                          rst_n,
  input  logic                          ld_en,
  input  logic [ADDR_W-1:0]             ld_addr,
  input  logic [INSTR_W-1:0]            ld_data,
  input  logic                          fetch_en,
  input  logic                          redirect,
  input  logic [ADDR_W-1:0]             redirect_pc,
  input  logic                          issue_ready,
  output logic                          issue_valid,
  output logic [INSTR_W-1:0]            issue_instr,
  output logic [ADDR_W-1:0]             issue_pc,
  output logic [ADDR_W-1:0]             pc_out,
  output logic [$clog2(QDEPTH+1)-1:0]   q_count,
  output logic                          halted
);

  localparam int MEM_DEPTH = 1 << ADDR_W;
  localparam int PTR_W     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CNT_W     = $clog2(QDEPTH + 1);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(QDEPTH);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(QDEPTH - 1);

  logic [INSTR_W-1:0] mem_q [MEM_DEPTH];

  logic [INSTR_W-1:0] qinstr_q [QDEPTH];
  logic [ADDR_W-1:0]  qpc_q    [QDEPTH];

  logic [ADDR_W-1:0] pc_q,     pc_d;
  logic [PTR_W-1:0]  head_q,   head_d;
  logic [PTR_W-1:0]  tail_q,   tail_d;
  logic [CNT_W-1:0]  cnt_q,    cnt_d;
  logic              halted_q, halted_d;

  logic              deq;
  logic              fetch;
  logic [INSTR_W-1:0] fetch_word;

  // Circular pointer advance; QDEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // The registered memory gives the pre-edge word, so a same-edge load to
  // pc_out cannot be seen by the fetch.
  assign fetch_word = mem_q[pc_q];

  // Handshake decode and next-state for PC, pointers, count and halt flag.
  always_comb begin
    deq      = (cnt_q != '0) && issue_ready && !redirect;
    fetch    = fetch_en && !halted_q && !redirect && ((cnt_q != CNT_FULL) || deq);
    pc_d     = pc_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    halted_d = halted_q;
    if (redirect) begin
      pc_d     = redirect_pc;
      head_d   = '0;
      tail_d   = '0;
      cnt_d    = '0;
      halted_d = 1'b0;
    end else begin
      if (deq) begin
        head_d = next_ptr(head_q);
      end
      if (fetch) begin
        tail_d = next_ptr(tail_q);
        pc_d   = pc_q + 1'b1;
        if (fetch_word == HALT_WORD) begin
          halted_d = 1'b1;
        end
      end
      case ({fetch, deq})
        2'b10:   cnt_d = cnt_q + 1'b1;
        2'b01:   cnt_d = cnt_q - 1'b1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Control state register with asynchronous clear.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      halted_q <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      halted_q <= halted_d;
    end
  end

  // Program memory: cleared while in reset, written by the load port.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MEM_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Queue payload storage; validity is tracked by the count, so no reset.
  always_ff @(posedge clk1) begin
    if (fetch) begin
      qinstr_q[tail_q] <= fetch_word;
      qpc_q[tail_q]    <= pc_q;
    end
  end

  assign issue_valid = (cnt_q != '0);
  assign issue_instr = qinstr_q[head_q];
  assign issue_pc    = qpc_q[head_q];
  assign pc_out      = pc_q;
  assign q_count     = cnt_q;
  assign halted      = halted_q;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Directed bench for instr_fetch_queue with a scoreboard of expected issues.
module tb_instr_fetch_queue;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        ld_en;
  logic [3:0]  ld_addr;
  logic [15:0] ld_data;
  logic        fetch_en;
  logic        redirect;
  logic [3:0]  redirect_pc;
  logic        issue_ready;
  logic        issue_valid;
  logic [15:0] issue_instr;
  logic [3:0]  issue_pc;
  logic [3:0]  pc_out;
  logic [2:0]  q_count;
  logic        halted;

  int n_cmp = 0;
  int n_mis = 0;

  typedef struct packed {
    logic [15:0] instr;
    logic [3:0]  pc;
  } exp_t;

  exp_t sb[$];

  instr_fetch_queue dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .ld_en       (ld_en),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .fetch_en    (fetch_en),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .issue_ready (issue_ready),
    .issue_valid (issue_valid),
    .issue_instr (issue_instr),
    .issue_pc    (issue_pc),
    .pc_out      (pc_out),
    .q_count     (q_count),
    .halted      (halted)
  );

  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic load(input logic [3:0] a, input logic [15:0] d);
    ld_en   = 1'b1;
    ld_addr = a;
    ld_data = d;
    step();
    ld_en   = 1'b0;
  endtask

  task automatic do_redirect(input logic [3:0] p);
    redirect    = 1'b1;
    redirect_pc = p;
    step();
    redirect    = 1'b0;
  endtask

  task automatic push(input logic [15:0] i, input logic [3:0] p);
    exp_t e;
    e.instr = i;
    e.pc    = p;
    sb.push_back(e);
  endtask

  // Monitor: every handshake that will complete on the next edge is checked
  // against the head of the scoreboard; also checks valid tracks the count.
  always @(negedge clk1) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if (issue_valid !== (q_count != 0)) begin
        n_mis++;
        $display("FAIL valid_vs_count: valid %0b count %0d", issue_valid, q_count);
      end
      if (issue_valid && issue_ready && !redirect) begin
        n_cmp++;
        if (sb.size() == 0) begin
          n_mis++;
          $display("FAIL unexpected_issue: got instr %h pc %0d, expected none", issue_instr, issue_pc);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (issue_instr !== e.instr || issue_pc !== e.pc) begin
            n_mis++;
            $display("FAIL issue: got instr %h pc %0d expected instr %h pc %0d",
                     issue_instr, issue_pc, e.instr, e.pc);
          end
        end
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    ld_en       = 1'b0;
    ld_addr     = '0;
    ld_data     = '0;
    fetch_en    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    issue_ready = 1'b0;
    #1;
    chk("reset_count", q_count, 0);
    chk("reset_pc", pc_out, 0);
    chk("reset_valid", issue_valid, 0);
    chk("reset_halted", halted, 0);
    step();
    step();
    rst_n = 1'b1;

    // Program image
    load(4'd0, 16'h2123);
    load(4'd1, 16'h0345);
    load(4'd2, 16'h0267);
    load(4'd3, 16'h089A);
    load(4'd9, 16'h1234);
    load(4'd15, 16'hABCD);

    // Streaming fetch with a ready consumer
    push(16'h2123, 4'd0);
    push(16'h0345, 4'd1);
    push(16'h0267, 4'd2);
    push(16'h089A, 4'd3);
    fetch_en    = 1'b1;
    issue_ready = 1'b1;
    chk("s1_valid_before", issue_valid, 0);
    step();
    chk("s1_first_valid", issue_valid, 1);
    chk("s1_first_count", q_count, 1);
    repeat (3) step();
    fetch_en = 1'b0;
    repeat (2) step();
    chk("s1_end_count", q_count, 0);
    chk("s1_end_pc", pc_out, 4);

    // Saturate with a stalled consumer, then simultaneous enqueue/dequeue
    issue_ready = 1'b0;
    do_redirect(4'd0);
    push(16'h2123, 4'd0);
    push(16'h0345, 4'd1);
    push(16'h0267, 4'd2);
    push(16'h089A, 4'd3);
    push(16'h0000, 4'd4);
    push(16'h0000, 4'd5);
    push(16'h0000, 4'd6);
    fetch_en = 1'b1;
    step();
    chk("s2_count1", q_count, 1);
    step();
    chk("s2_count2", q_count, 2);
    repeat (4) step();
    chk("s2_count_sat", q_count, 4);
    chk("s2_pc_sat", pc_out, 4);
    issue_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("s2_full_flow_count", q_count, 4);
    end
    chk("s2_full_flow_pc", pc_out, 7);
    fetch_en = 1'b0;
    repeat (4) step();
    chk("s2_drain_count", q_count, 0);

    // Halt on HALT_WORD
    load(4'd2, 16'hFFFF);
    do_redirect(4'd0);
    push(16'h2123, 4'd0);
    push(16'h0345, 4'd1);
    push(16'hFFFF, 4'd2);
    fetch_en = 1'b1;
    repeat (2) step();
    chk("s3_not_halted", halted, 0);
    step();
    chk("s3_halted", halted, 1);
    chk("s3_halt_pc", pc_out, 3);
    repeat (4) step();
    chk("s3_stay_pc", pc_out, 3);
    chk("s3_stay_count", q_count, 0);
    chk("s3_stay_halted", halted, 1);
    chk("s3_sb_empty", sb.size(), 0);

    // Redirect flushes a partially filled queue
    issue_ready = 1'b0;
    do_redirect(4'd0);
    chk("s4_unhalt", halted, 0);
    repeat (3) step();
    chk("s4_count3", q_count, 3);
    redirect    = 1'b1;
    redirect_pc = 4'd9;
    step();
    redirect    = 1'b0;
    chk("s4_flush_count", q_count, 0);
    chk("s4_flush_valid", issue_valid, 0);
    chk("s4_flush_pc", pc_out, 9);
    chk("s4_flush_halted", halted, 0);
    push(16'h1234, 4'd9);
    issue_ready = 1'b1;
    step();
    fetch_en = 1'b0;
    repeat (2) step();
    chk("s4_pc_after", pc_out, 10);
    chk("s4_count_after", q_count, 0);

    // PC wrap from 15 to 0
    do_redirect(4'd15);
    push(16'hABCD, 4'd15);
    push(16'h2123, 4'd0);
    fetch_en = 1'b1;
    repeat (2) step();
    fetch_en = 1'b0;
    repeat (2) step();
    chk("s5_wrap_pc", pc_out, 1);
    chk("s5_count", q_count, 0);

    // Asynchronous reset with entries queued
    issue_ready = 1'b0;
    do_redirect(4'd0);
    fetch_en = 1'b1;
    repeat (2) step();
    fetch_en = 1'b0;
    chk("s6_count2", q_count, 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("s6_rst_count", q_count, 0);
    chk("s6_rst_pc", pc_out, 0);
    chk("s6_rst_valid", issue_valid, 0);
    @(posedge clk1);
    #1;
    rst_n = 1'b1;

    // Memory cleared by reset; fetch reads before a same-edge load
    push(16'h0000, 4'd0);
    ld_en       = 1'b1;
    ld_addr     = 4'd0;
    ld_data     = 16'h5555;
    fetch_en    = 1'b1;
    issue_ready = 1'b1;
    step();
    ld_en    = 1'b0;
    fetch_en = 1'b0;
    repeat (2) step();
    do_redirect(4'd0);
    push(16'h5555, 4'd0);
    fetch_en = 1'b1;
    step();
    fetch_en = 1'b0;
    repeat (2) step();
    chk("s7_pc", pc_out, 1);
    chk("final_sb_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
